mod_sub_pipe: RTL
=================

Name: mod_sub_pipe

Overview:
- Pipelined modular subtractor for the NTT/FFT butterfly datapath. Computes (a − b) mod MODULUS.
- Built from 16-bit borrow-lookahead groups. It is the subtract-side counterpart of the carry-lookahead adder tree.
- Takes operand pairs through a valid/ready handshake. Returns reduced differences after a fixed three-stage pipeline, with full backpressure.

Parameters:
- DATA_WIDTH, 64, operand/result width; must be a multiple of 16.
- MODULUS, 64'hFFFFFFFF00000001, prime modulus; must be < 2^DATA_WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands this cycle
- in_a  input  DATA_WIDTH  minuend, expected < MODULUS
- in_b  input  DATA_WIDTH  subtrahend, expected < MODULUS
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  DATA_WIDTH  (in_a − in_b) mod MODULUS

Behaviour:
- Reset: one clock; async active-low reset, released synchronously to clk. While rst_n=0, all stage valid flags, out_valid and out_data are 0. in_ready is 1 once out of reset.
- Stall: stall = out_valid & ~out_ready. in_ready = ~stall. When stall=1, all pipeline registers hold, including data and valid bits. Otherwise every stage advances.
- Transfer: an input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
- Stage 1 (S1):
  - Register a and ~b.
  - Per bit: generate g = a & ~b, propagate p = a | ~b.
  - Per 16-bit group: group G/P (4-level lookahead as in the adder tree) and group-local sums with carry-in 0 and 1.
  - S1 valid = accepted input.
- Stage 2 (S2):
  - Resolve inter-group carries with a lookahead across groups; global carry-in = 1 (two's-complement subtract).
  - Select each group sum from its resolved carry-in.
  - Register raw difference d = (a − b) mod 2^DATA_WIDTH and borrow = ~carry_out.
- Stage 3 (S3 / output register):
  - If borrow=1, out_data = d + MODULUS (mod 2^DATA_WIDTH); else out_data = d.
  - out_valid = S2 valid.
- Latency: exactly 3 cycles from input transfer to out_valid, absent stalls. Throughput is 1 result per cycle.
- Ordering: results leave in acceptance order. No drops, no duplicates, no reordering under any out_ready pattern.
- Bubbles: invalid stage slots advance normally. Bubbles are not compressed; a stall freezes the whole pipe even if S1/S2 are empty.
- Out-of-range operands (≥ MODULUS): no reduction on input. The output follows the same d/borrow rule, and is not guaranteed < MODULUS.
- out_data when out_valid=0: holds its last value; not significant.
- Reset mid-operation: all in-flight operands are discarded. Nothing is output after reset deasserts until new inputs are accepted.
- Equal operands (a=b): borrow=0, out_data=0.

Test Plan:
1. Assert rst_n=0 with in_valid=1 → out_valid=0, out_data=0, no transfers. Release reset → in_ready=1 in the first active cycle.
2. a=10, b=3, out_ready=1 → out_valid=1 three cycles later with out_data=7. Then a=b=0x1234 → out_data=0.
3. a=3, b=10 → borrow corrected, out_data=0xFFFFFFFEFFFFFFFA. Also a=0, b=1 → out_data=0xFFFFFFFF00000000.
4. Cross-group borrow ripple: a=0x0000000100000000, b=1 → out_data=0x00000000FFFFFFFF. Also a=0x0001000000000000, b=0x0000000000000001 → out_data=0x0000FFFFFFFFFFFF.
5. Stream 20 back-to-back random pairs with out_ready toggled pseudo-randomly. Hold out_ready=0 for 5 cycles mid-stream → in_ready=0 for that window, out_data stable while stalled, all 20 results correct and in order against a reference model.
6. Pulse rst_n low for one cycle while 3 operations are in flight → out_valid=0 immediately, none of the 3 results ever appear. The next accepted pair produces a correct result after 3 cycles.

Source files
------------

// File: rtl/mod_sub_pipe.sv
// Three-stage pipelined modular subtractor: (a - b) mod MODULUS.
// 16-bit borrow-lookahead groups, valid/ready handshake, whole-pipe stall on output backpressure.
module mod_sub_pipe #(
  parameter int                    DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] MODULUS    = 64'hFFFF_FFFF_0000_0001
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int NG = DATA_WIDTH / 16;

  // Carries into positions 0..3 of a 4-wide lookahead block.
  function automatic logic [3:0] lah4(input logic [3:0] g, input logic [3:0] p, input logic cin);
    logic [3:0] c;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

  function automatic logic gen4(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  // Group-local sum for a given carry-in: nibble lookahead, then bit lookahead.
  function automatic logic [15:0] grp_sum(input logic [15:0] g, input logic [15:0] p,
                                          input logic [15:0] x, input logic cin);
    logic [3:0]  ng;
    logic [3:0]  np;
    logic [3:0]  nc;
    logic [3:0]  bc;
    logic [15:0] s;
    for (int n = 0; n < 4; n++) begin
      ng[n] = gen4(g[4*n +: 4], p[4*n +: 4]);
      np[n] = &p[4*n +: 4];
    end
    nc = lah4(ng, np, cin);
    for (int n = 0; n < 4; n++) begin
      bc         = lah4(g[4*n +: 4], p[4*n +: 4], nc[n]);
      s[4*n +: 4] = x[4*n +: 4] ^ bc;
    end
    return s;
  endfunction

  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // ---------------- Stage 1: per-group generate/propagate and dual sums
  logic [NG-1:0][15:0] sum0_n, sum1_n;
  logic [NG-1:0]       gg_n, gp_n;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    logic [15:0] ga, gnb, g, p, x;
    logic [3:0]  ng, np;
    sum0_n = '0;
    sum1_n = '0;
    gg_n   = '0;
    gp_n   = '0;
    for (int gi = 0; gi < NG; gi++) begin
      ga  = in_a[16*gi +: 16];
      gnb = ~in_b[16*gi +: 16];
      g   = ga & gnb;
      p   = ga | gnb;
      x   = ga ^ gnb;
      for (int n = 0; n < 4; n++) begin
        ng[n] = gen4(g[4*n +: 4], p[4*n +: 4]);
        np[n] = &p[4*n +: 4];
      end
      gg_n[gi]   = gen4(ng, np);
      gp_n[gi]   = &np;
      sum0_n[gi] = grp_sum(g, p, x, 1'b0);
      sum1_n[gi] = grp_sum(g, p, x, 1'b1);
    end
  end

  logic                s1_valid;
  logic [NG-1:0][15:0] s1_sum0, s1_sum1;
  logic [NG-1:0]       s1_g, s1_p;

  // NOTE: sequential state uses non-blocking assignments only; blocking here would race between stages.
  // NOTE: datapath registers are reset too, so out_data reads 0 during reset rather than stale values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sum0  <= '0;
      s1_sum1  <= '0;
      s1_g     <= '0;
      s1_p     <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sum0 <= sum0_n;
        s1_sum1 <= sum1_n;
        s1_g    <= gg_n;
        s1_p    <= gp_n;
      end
    end
  end

  // ---------------- Stage 2: inter-group lookahead with carry-in 1, select sums
  logic [NG:0]           cg;
  logic [DATA_WIDTH-1:0] d_n;

  always_comb begin
    logic prod;
    cg    = '0;
    d_n   = '0;
    cg[0] = 1'b1;
    for (int i = 1; i <= NG; i++) begin
      cg[i] = s1_g[i-1];
      prod  = s1_p[i-1];
      for (int j = i - 2; j >= 0; j--) begin
        cg[i] = cg[i] | (prod & s1_g[j]);
        prod  = prod & s1_p[j];
      end
      cg[i] = cg[i] | prod;
    end
    for (int i = 0; i < NG; i++)
      d_n[16*i +: 16] = cg[i] ? s1_sum1[i] : s1_sum0[i];
  end

  logic                  s2_valid;
  logic [DATA_WIDTH-1:0] s2_d;
  logic                  s2_borrow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_d      <= '0;
      s2_borrow <= 1'b0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_d      <= d_n;
        s2_borrow <= ~cg[NG];
      end
    end
  end

  // ---------------- Stage 3: modular correction into the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (!stall) begin
      out_valid <= s2_valid;
      if (s2_valid)
        out_data <= s2_borrow ? s2_d + MODULUS : s2_d;
    end
  end

endmodule
